// File: rtl/fb_arbiter_if.sv
// Framebuffer arbiter bus bundle: VGA scan-out, CPU graphics bus, fill control and BRAM port.
// The slave modport is the arbiter's view and the master modport is the surrounding system's view.
interface fb_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              pix_en_i;
    logic              in_disp_i;
    logic [ADDR_W-1:0] pixel_pos_i;
    logic [DATA_W-1:0] pixel_o;
    logic              pixel_valid_o;

    logic              cpu_req_i;
    logic              cpu_we_i;
    logic [ADDR_W-1:0] cpu_addr_i;
    logic [DATA_W-1:0] cpu_wdata_i;
    logic              cpu_ack_o;
    logic [DATA_W-1:0] cpu_rdata_o;

    logic              fill_start_i;
    logic [DATA_W-1:0] fill_color_i;
    logic              fill_busy_o;

    logic              mem_en_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;

    modport slave (
        input  pix_en_i, in_disp_i, pixel_pos_i,
        output pixel_o, pixel_valid_o,
        input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
        output cpu_ack_o, cpu_rdata_o,
        input  fill_start_i, fill_color_i,
        output fill_busy_o,
        output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i
    );

    modport master (
        output pix_en_i, in_disp_i, pixel_pos_i,
        input  pixel_o, pixel_valid_o,
        output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
        input  cpu_ack_o, cpu_rdata_o,
        output fill_start_i, fill_color_i,
        input  fill_busy_o,
        input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i
    );
endinterface

// File: rtl/fb_arbiter.sv
// Single-port framebuffer arbiter: VGA pixel slots first, then the fill engine, then CPU accesses.
// Read data returns one cycle after the grant and is steered by a registered return tag.
module fb_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input logic        clk,
    input logic        rst_n,
    fb_arbiter_if.slave bus
);
    typedef enum logic [1:0] {CPU_IDLE, CPU_RD_PEND, CPU_ACK} cpu_state_t;
    typedef enum logic [1:0] {TAG_NONE, TAG_VGA, TAG_CPU} tag_t;

    cpu_state_t        cpu_state;
    cpu_state_t        cpu_next;
    tag_t              tag_p1;
    tag_t              tag_next;

    logic              gnt_vga;
    logic              gnt_fill;
    logic              gnt_cpu;
    logic              fill_busy;
    logic              fill_accept;
    logic [ADDR_W-1:0] fill_cnt;
    logic [DATA_W-1:0] fill_color;

    logic [DATA_W-1:0] pixel_p2;
    logic              vld_p2;
    logic [DATA_W-1:0] cpu_rdata_p2;

    // Grants are masked during reset so the RAM port stays quiet.
    always_comb begin
        gnt_vga  = rst_n & bus.pix_en_i & bus.in_disp_i;
        gnt_fill = rst_n & ~gnt_vga & fill_busy;
        gnt_cpu  = rst_n & ~gnt_vga & ~fill_busy & bus.cpu_req_i & (cpu_state == CPU_IDLE);
    end

    assign fill_accept = bus.fill_start_i & ~fill_busy;

    always_comb begin
        bus.mem_en_o    = 1'b0;
        bus.mem_we_o    = 1'b0;
        bus.mem_addr_o  = '0;
        bus.mem_wdata_o = '0;
        if (gnt_vga) begin
            bus.mem_en_o   = 1'b1;
            bus.mem_addr_o = bus.pixel_pos_i;
        end else if (gnt_fill) begin
            bus.mem_en_o    = 1'b1;
            bus.mem_we_o    = 1'b1;
            bus.mem_addr_o  = fill_cnt;
            bus.mem_wdata_o = fill_color;
        end else if (gnt_cpu) begin
            bus.mem_en_o    = 1'b1;
            bus.mem_we_o    = bus.cpu_we_i;
            bus.mem_addr_o  = bus.cpu_addr_i;
            bus.mem_wdata_o = bus.cpu_we_i ? bus.cpu_wdata_i : '0;
        end
    end

    always_comb begin
        cpu_next      = cpu_state;
        tag_next      = TAG_NONE;
        bus.cpu_ack_o = 1'b0;
        unique case (cpu_state)
            CPU_IDLE: begin
                if (gnt_cpu) begin
                    cpu_next = bus.cpu_we_i ? CPU_ACK : CPU_RD_PEND;
                end
            end
            CPU_RD_PEND: cpu_next = CPU_ACK;
            CPU_ACK: begin
                cpu_next      = CPU_IDLE;
                bus.cpu_ack_o = 1'b1;
            end
            default: cpu_next = CPU_IDLE;
        endcase
        if (gnt_vga) begin
            tag_next = TAG_VGA;
        end else if (gnt_cpu && !bus.cpu_we_i) begin
            tag_next = TAG_CPU;
        end
    end

    // Stage p1: read in flight (tag); stage p2: returned data registered to its owner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_state    <= CPU_IDLE;
            tag_p1       <= TAG_NONE;
            fill_busy    <= 1'b0;
            pixel_p2     <= '0;
            vld_p2       <= 1'b0;
            cpu_rdata_p2 <= '0;
        end else begin
            cpu_state <= cpu_next;
            tag_p1    <= tag_next;
            vld_p2    <= (tag_p1 == TAG_VGA);
            if (tag_p1 == TAG_VGA) begin
                pixel_p2 <= bus.mem_rdata_i;
            end
            if (tag_p1 == TAG_CPU) begin
                cpu_rdata_p2 <= bus.mem_rdata_i;
            end
            if (fill_accept) begin
                fill_busy <= 1'b1;
            end else if (gnt_fill && (&fill_cnt)) begin
                fill_busy <= 1'b0;
            end
        end
    end

    // Fill address and colour are only meaningful while fill_busy is set.
    always_ff @(posedge clk) begin
        if (fill_accept) begin
            fill_cnt   <= '0;
            fill_color <= bus.fill_color_i;
        end else if (gnt_fill) begin
            fill_cnt <= fill_cnt + 1'b1;
        end
    end

    assign bus.pixel_o       = pixel_p2;
    assign bus.pixel_valid_o = vld_p2;
    assign bus.cpu_rdata_o   = cpu_rdata_p2;
    assign bus.fill_busy_o   = fill_busy;
endmodule

// File: tb/tb_fb_arbiter.sv
// Bench for fb_arbiter: directed scenarios plus randomized traffic, checked every cycle
// against a transaction-level model of the arbitration rules and a shadow framebuffer.
module tb_fb_arbiter;
    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    fb_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Framebuffer RAM: synchronous read, preloaded with each location's own address.
    logic [DW-1:0] ram [DEPTH];
    logic [DW-1:0] ram_q      = '0;
    logic          ram_loaded = 1'b0;
    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= DW'(i);
            ram_loaded <= 1'b1;
        end else if (bus.mem_en_o) begin
            if (bus.mem_we_o) ram[bus.mem_addr_o] <= bus.mem_wdata_o;
            else              ram_q <= ram[bus.mem_addr_o];
        end
    end
    assign bus.mem_rdata_i = ram_q;

    int wr_3c = 0;
    int wr_ff = 0;
    always @(posedge clk) begin
        if (rst_n && bus.mem_en_o && bus.mem_we_o) begin
            if (bus.mem_wdata_o == 8'h3C) wr_3c <= wr_3c + 1;
            if (bus.mem_wdata_o == 8'hFF) wr_ff <= wr_ff + 1;
        end
    end

    // Behavioural model and per-cycle comparison, evaluated mid-cycle once inputs are settled.
    typedef struct { int cyc; logic [DW-1:0] d; } pix_ev_t;
    initial begin : compare
        pix_ev_t                  pq[$];
        logic [DW-1:0]            shadow [DEPTH];
        logic [1+1+AW+DW-1:0]     e_bus;
        int                       cyc;
        int                       cpu_free_after;
        int                       ack_cyc;
        logic [DW-1:0]            ack_data;
        logic                     ack_rd;
        logic [DW-1:0]            m_pixel;
        logic [DW-1:0]            m_rdata;
        logic                     e_pvld;
        logic                     e_ack;
        logic                     m_fill;
        logic                     was_fill;
        int                       fill_idx;
        logic [DW-1:0]            fill_color;
        pix_ev_t                  ev;
        int                       kind;

        for (int i = 0; i < DEPTH; i++) shadow[i] = DW'(i);
        cyc = 1; cpu_free_after = 0; ack_cyc = 0; ack_data = '0; ack_rd = 1'b0;
        m_pixel = '0; m_rdata = '0; m_fill = 1'b0; fill_idx = 0; fill_color = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                check("reset_outputs",
                      {bus.mem_en_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o, bus.pixel_o,
                       bus.pixel_valid_o, bus.cpu_ack_o, bus.cpu_rdata_o, bus.fill_busy_o}, 64'd0);
                pq.delete();
                cpu_free_after = 0; ack_cyc = 0; m_pixel = '0; m_rdata = '0; m_fill = 1'b0;
            end else begin
                e_pvld = 1'b0;
                if (pq.size() > 0 && pq[0].cyc == cyc) begin
                    m_pixel = pq[0].d;
                    e_pvld  = 1'b1;
                    void'(pq.pop_front());
                end
                e_ack = (ack_cyc == cyc);
                if (e_ack && ack_rd) m_rdata = ack_data;

                kind  = 0;
                e_bus = '0;
                if (bus.pix_en_i && bus.in_disp_i) begin
                    kind  = 1;
                    e_bus = {1'b1, 1'b0, bus.pixel_pos_i, 8'h00};
                end else if (m_fill) begin
                    kind  = 2;
                    e_bus = {1'b1, 1'b1, AW'(fill_idx), fill_color};
                end else if (bus.cpu_req_i && cyc > cpu_free_after) begin
                    kind  = 3;
                    e_bus = {1'b1, bus.cpu_we_i, bus.cpu_addr_i,
                             (bus.cpu_we_i ? bus.cpu_wdata_i : 8'h00)};
                end

                check("mem_bus", {bus.mem_en_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o}, e_bus);
                check("pixel", {bus.pixel_valid_o, bus.pixel_o}, {e_pvld, m_pixel});
                check("cpu_resp", {bus.cpu_ack_o, bus.cpu_rdata_o}, {e_ack, m_rdata});
                check("fill_busy", bus.fill_busy_o, m_fill);

                was_fill = m_fill;
                case (kind)
                    1: begin
                        ev.cyc = cyc + 2;
                        ev.d   = shadow[bus.pixel_pos_i];
                        pq.push_back(ev);
                    end
                    2: begin
                        shadow[fill_idx] = fill_color;
                        if (fill_idx == DEPTH - 1) m_fill = 1'b0;
                        fill_idx++;
                    end
                    3: begin
                        if (bus.cpu_we_i) begin
                            shadow[bus.cpu_addr_i] = bus.cpu_wdata_i;
                            ack_cyc = cyc + 1;
                            ack_rd  = 1'b0;
                        end else begin
                            ack_cyc  = cyc + 2;
                            ack_rd   = 1'b1;
                            ack_data = shadow[bus.cpu_addr_i];
                        end
                        cpu_free_after = ack_cyc;
                    end
                    default: ;
                endcase
                if (bus.fill_start_i && !was_fill) begin
                    m_fill     = 1'b1;
                    fill_idx   = 0;
                    fill_color = bus.fill_color_i;
                end
            end
            cyc++;
        end
    end

    // Stimulus side: a CPU requester that holds its request until acknowledged.
    int            pix_mode = 0;
    logic          ack_seen = 1'b0;
    logic [DW-1:0] rdata_seen = '0;

    task automatic tick();
        @(negedge clk);
        bus.fill_start_i = 1'b0;
        ack_seen   = bus.cpu_ack_o;
        rdata_seen = bus.cpu_rdata_o;
        if (bus.cpu_ack_o) bus.cpu_req_i = 1'b0;
        case (pix_mode)
            0:       bus.pix_en_i = 1'b0;
            1:       bus.pix_en_i = ~bus.pix_en_i;
            default: bus.pix_en_i = ~bus.pix_en_i & ($urandom_range(0, 1) == 1);
        endcase
    endtask

    task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.cpu_we_i    = we;
        bus.cpu_addr_i  = a;
        bus.cpu_wdata_i = d;
        bus.cpu_req_i   = 1'b1;
    endtask

    task automatic wait_ack(input int bound, output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!ack_seen && lat < bound);
        check("ack_within_bound", ack_seen, 1'b1);
    endtask

    initial begin : timeout
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        int lat;
        int bad;
        int base_3c;
        int base_ff;
        int rst_hold;

        bus.pix_en_i = 1'b0; bus.in_disp_i = 1'b0; bus.pixel_pos_i = '0;
        bus.cpu_req_i = 1'b0; bus.cpu_we_i = 1'b0; bus.cpu_addr_i = '0; bus.cpu_wdata_i = '0;
        bus.fill_start_i = 1'b0; bus.fill_color_i = '0;
        repeat (3) tick();
        rst_n = 1'b1;

        // VGA read of position 2 returns the preloaded value two cycles after the slot.
        pix_mode = 1; bus.in_disp_i = 1'b1; bus.pixel_pos_i = 4'h2;
        tick();
        if (!bus.pix_en_i) tick();
        #1 check("vga_addr", {bus.mem_en_o, bus.mem_addr_o}, {1'b1, 4'h2});
        tick(); tick();
        #1 check("vga_pixel", {bus.pixel_valid_o, bus.pixel_o}, {1'b1, 8'h02});

        // CPU write then read back with no contention.
        pix_mode = 0; bus.in_disp_i = 1'b0;
        tick();
        issue(1'b1, 4'h4, 8'hA5);
        wait_ack(50, lat);
        check("cpu_wr_latency", lat, 1);
        tick();
        issue(1'b0, 4'h4, 8'h00);
        wait_ack(50, lat);
        check("cpu_rd_latency", lat, 2);
        check("cpu_rd_data", rdata_seen, 8'hA5);

        // Reset while the read is pending: no ack, outputs cleared, reissue completes.
        tick();
        issue(1'b0, 4'h4, 8'h00);
        tick();
        rst_n = 1'b0;
        #1 check("rst_mid_read", {bus.cpu_ack_o, bus.cpu_rdata_o, bus.pixel_o, bus.pixel_valid_o,
                                  bus.fill_busy_o, bus.mem_en_o}, 64'd0);
        tick(); tick();
        rst_n = 1'b1;
        wait_ack(50, lat);
        check("rst_reissue_data", rdata_seen, 8'hA5);

        // CPU request in a display slot waits exactly one cycle.
        pix_mode = 1; bus.in_disp_i = 1'b1; bus.pixel_pos_i = 4'h7;
        tick();
        if (!bus.pix_en_i) tick();
        issue(1'b0, 4'h3, 8'h00);
        wait_ack(50, lat);
        check("contention_latency", lat, 3);
        check("contention_data", rdata_seen, 8'h03);

        // Fill with 0x3C, CPU write stalled behind it, restart attempt with 0xFF ignored.
        tick();
        base_3c = wr_3c; base_ff = wr_ff;
        bus.fill_start_i = 1'b1; bus.fill_color_i = 8'h3C;
        tick();
        issue(1'b1, 4'h5, 8'h77);
        repeat (5) tick();
        bus.fill_start_i = 1'b1; bus.fill_color_i = 8'hFF;
        wait_ack(400, lat);
        check("cpu_after_fill", bus.fill_busy_o, 1'b0);
        tick();
        check("fill_write_count", wr_3c - base_3c, 16);
        check("fill_ignored_restart", wr_ff - base_ff, 0);
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ram[i] !== ((i == 5) ? 8'h77 : 8'h3C)) bad++;
        end
        check("fill_ram_contents", bad, 0);

        // Randomized traffic with occasional fills and resets.
        pix_mode = 2;
        rst_hold = 0;
        for (int n = 0; n < 4000; n++) begin
            tick();
            if (rst_hold > 0) begin
                rst_hold--;
                if (rst_hold == 0) rst_n = 1'b1;
            end else if ($urandom_range(0, 699) == 0) begin
                rst_n    = 1'b0;
                rst_hold = $urandom_range(1, 3);
            end
            bus.in_disp_i   = ($urandom_range(0, 3) != 0);
            bus.pixel_pos_i = AW'($urandom_range(0, DEPTH - 1));
            if (!bus.cpu_req_i && $urandom_range(0, 3) == 0) begin
                issue($urandom_range(0, 1) == 1, AW'($urandom_range(0, DEPTH - 1)),
                      DW'($urandom_range(0, 255)));
            end
            if ($urandom_range(0, 399) == 0) begin
                bus.fill_start_i = 1'b1;
                bus.fill_color_i = DW'($urandom_range(0, 255));
            end
        end
        rst_n = 1'b1;
        pix_mode = 0;
        bus.in_disp_i = 1'b0;
        repeat (100) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
